// File: rtl/gray_counter_arb_if.sv
// Two-client request/ack bundle plus the method-style handshake to the shared gray counter.
interface gray_counter_arb_if #(parameter int WIDTH = 10);
  logic             c0_inc_req, c0_dec_req, c0_load_req, c0_ack;
  logic             c1_inc_req, c1_dec_req, c1_load_req, c1_ack;
  logic [WIDTH-1:0] c0_load_val, c1_load_val;
  logic             cnt_increment__ENA, cnt_decrement__ENA, cnt_writeBin__ENA;
  logic             cnt_increment__RDY, cnt_decrement__RDY, cnt_writeBin__RDY;
  logic [WIDTH-1:0] cnt_writeBin_v, cnt_readBin;
  logic             sat, proto_err;

  modport slave (
    input  c0_inc_req, c0_dec_req, c0_load_req, c0_load_val,
    input  c1_inc_req, c1_dec_req, c1_load_req, c1_load_val,
    input  cnt_increment__RDY, cnt_decrement__RDY, cnt_writeBin__RDY, cnt_readBin,
    output c0_ack, c1_ack, sat, proto_err,
    output cnt_increment__ENA, cnt_decrement__ENA, cnt_writeBin__ENA, cnt_writeBin_v
  );

  modport master (
    output c0_inc_req, c0_dec_req, c0_load_req, c0_load_val,
    output c1_inc_req, c1_dec_req, c1_load_req, c1_load_val,
    output cnt_increment__RDY, cnt_decrement__RDY, cnt_writeBin__RDY, cnt_readBin,
    input  c0_ack, c1_ack, sat, proto_err,
    input  cnt_increment__ENA, cnt_decrement__ENA, cnt_writeBin__ENA, cnt_writeBin_v
  );
endinterface

// File: rtl/gray_counter_arb.sv
// Two-client arbiter for a shared counter: loads beat inc/dec, opposite inc/dec cancel,
// ties go round-robin. One op is decided in IDLE and issued in ISSUE.
module gray_counter_arb #(
  parameter int WIDTH    = 10,
  parameter bit SATURATE = 1'b0
) (
  input logic               CLK,
  input logic               nRST,
  gray_counter_arb_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_INC, OP_DEC, OP_LOAD, OP_NET} op_t;

  state_t           state, state_nx;
  op_t              op_q, op_nx;
  logic [1:0]       grant_q, grant_nx;
  logic [WIDTH-1:0] lval_q, lval_nx;
  logic             rr_q, rr_nx, perr_q;

  logic [1:0]            inc, dec, ld, vld, bad, ack;
  logic [1:0][WIDTH-1:0] lval;
  logic                  done, inc_ena, dec_ena, wb_ena, sat_o, win;

  // A client being acked this cycle is already retiring, so its request is hidden
  assign inc  = {bus.c1_inc_req,  bus.c0_inc_req}  & ~ack;
  assign dec  = {bus.c1_dec_req,  bus.c0_dec_req}  & ~ack;
  assign ld   = {bus.c1_load_req, bus.c0_load_req} & ~ack;
  assign lval = {bus.c1_load_val, bus.c0_load_val};
  assign vld  = (inc ^ dec) & ~ld;
  assign bad  = inc & dec & ~ld;

  always_comb begin
    done    = 1'b0;
    inc_ena = 1'b0;
    dec_ena = 1'b0;
    wb_ena  = 1'b0;
    sat_o   = 1'b0;
    if (state == ISSUE && !nRST) begin
      case (op_q)
        OP_INC:
          if (SATURATE && (&bus.cnt_readBin)) begin
            done  = 1'b1;
            sat_o = 1'b1;
          end else begin
            inc_ena = bus.cnt_increment__RDY;
            done    = inc_ena;
          end
        OP_DEC:
          if (SATURATE && (bus.cnt_readBin == '0)) begin
            done  = 1'b1;
            sat_o = 1'b1;
          end else begin
            dec_ena = bus.cnt_decrement__RDY;
            done    = dec_ena;
          end
        OP_LOAD: begin
          wb_ena = bus.cnt_writeBin__RDY;
          done   = wb_ena;
        end
        OP_NET:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign ack = done ? grant_q : 2'b00;

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    grant_nx = grant_q;
    lval_nx  = lval_q;
    rr_nx    = rr_q;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (|ld) begin
          win      = (&ld) ? rr_q : ld[1];
          op_nx    = OP_LOAD;
          grant_nx = win ? 2'b10 : 2'b01;
          lval_nx  = lval[win];
          rr_nx    = ~win;
          state_nx = ISSUE;
        end else if ((&vld) && (inc[0] != inc[1])) begin
          op_nx    = OP_NET;
          grant_nx = 2'b11;
          state_nx = ISSUE;
        end else if (|vld) begin
          win      = (&vld) ? rr_q : vld[1];
          op_nx    = inc[win] ? OP_INC : OP_DEC;
          grant_nx = win ? 2'b10 : 2'b01;
          rr_nx    = ~win;
          state_nx = ISSUE;
        end
      end
      ISSUE:
        if (done) begin
          state_nx = IDLE;
          op_nx    = OP_NONE;
          grant_nx = 2'b00;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state   <= IDLE;
      op_q    <= OP_NONE;
      grant_q <= 2'b00;
      lval_q  <= '0;
      rr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      op_q    <= op_nx;
      grant_q <= grant_nx;
      lval_q  <= lval_nx;
      rr_q    <= rr_nx;
      if (|bad) perr_q <= 1'b1;
    end
  end

  assign bus.c0_ack             = ack[0];
  assign bus.c1_ack             = ack[1];
  assign bus.cnt_increment__ENA = inc_ena;
  assign bus.cnt_decrement__ENA = dec_ena;
  assign bus.cnt_writeBin__ENA  = wb_ena;
  assign bus.cnt_writeBin_v     = lval_q;
  assign bus.sat                = sat_o;
  assign bus.proto_err          = perr_q;
endmodule

// File: tb/tb_gray_counter_arb.sv
// Bench: two arbiters (wrap / saturate) on shared client stimulus, each with a simple counter.
module tb_gray_counter_arb;
  localparam int W = 10;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  logic c0_inc = 0, c0_dec = 0, c0_ld = 0, c1_inc = 0, c1_dec = 0, c1_ld = 0;
  logic [W-1:0] c0_val = '0, c1_val = '0;
  logic rdy_inc = 1, rdy_dec = 1, rdy_wb = 1;
  logic [W-1:0] cnt0, cnt1, pre0 = '0, pre1 = '0;
  logic pre_en = 0;

  gray_counter_arb_if #(.WIDTH(W)) bus0 ();
  gray_counter_arb_if #(.WIDTH(W)) bus1 ();

  assign bus0.c0_inc_req = c0_inc;  assign bus1.c0_inc_req = c0_inc;
  assign bus0.c0_dec_req = c0_dec;  assign bus1.c0_dec_req = c0_dec;
  assign bus0.c0_load_req = c0_ld;  assign bus1.c0_load_req = c0_ld;
  assign bus0.c0_load_val = c0_val; assign bus1.c0_load_val = c0_val;
  assign bus0.c1_inc_req = c1_inc;  assign bus1.c1_inc_req = c1_inc;
  assign bus0.c1_dec_req = c1_dec;  assign bus1.c1_dec_req = c1_dec;
  assign bus0.c1_load_req = c1_ld;  assign bus1.c1_load_req = c1_ld;
  assign bus0.c1_load_val = c1_val; assign bus1.c1_load_val = c1_val;
  assign bus0.cnt_increment__RDY = rdy_inc; assign bus1.cnt_increment__RDY = rdy_inc;
  assign bus0.cnt_decrement__RDY = rdy_dec; assign bus1.cnt_decrement__RDY = rdy_dec;
  assign bus0.cnt_writeBin__RDY  = rdy_wb;  assign bus1.cnt_writeBin__RDY  = rdy_wb;
  assign bus0.cnt_readBin = cnt0;   assign bus1.cnt_readBin = cnt1;

  gray_counter_arb #(.WIDTH(W), .SATURATE(1'b0)) dut0 (.CLK(clk), .nRST(rst), .bus(bus0));
  gray_counter_arb #(.WIDTH(W), .SATURATE(1'b1)) dut1 (.CLK(clk), .nRST(rst), .bus(bus1));

  always @(posedge clk) begin
    if (pre_en) cnt0 <= pre0;
    else if (bus0.cnt_writeBin__ENA) cnt0 <= bus0.cnt_writeBin_v;
    else if (bus0.cnt_increment__ENA) cnt0 <= cnt0 + 1'b1;
    else if (bus0.cnt_decrement__ENA) cnt0 <= cnt0 - 1'b1;
  end

  always @(posedge clk) begin
    if (pre_en) cnt1 <= pre1;
    else if (bus1.cnt_writeBin__ENA) cnt1 <= bus1.cnt_writeBin_v;
    else if (bus1.cnt_increment__ENA) cnt1 <= cnt1 + 1'b1;
    else if (bus1.cnt_decrement__ENA) cnt1 <= cnt1 - 1'b1;
  end

  function automatic logic [2:0] enas0();
    return {bus0.cnt_writeBin__ENA, bus0.cnt_decrement__ENA, bus0.cnt_increment__ENA};
  endfunction
  function automatic logic [2:0] enas1();
    return {bus1.cnt_writeBin__ENA, bus1.cnt_decrement__ENA, bus1.cnt_increment__ENA};
  endfunction

  // op codes used by the bench: 0 none, 1 inc, 2 dec, 3 load, 4 inc+dec (illegal)
  function automatic logic [2:0] ena_of(input int o);
    case (o)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [W-1:0] apply(input logic [W-1:0] x, input int o, input logic [W-1:0] v);
    case (o)
      1: return W'((int'(x) + 1) % (1 << W));
      2: return W'((int'(x) + (1 << W) - 1) % (1 << W));
      3: return v;
      default: return x;
    endcase
  endfunction

  always @(negedge clk) begin
    vectors++;
    if ($countones(enas0()) > 1 || $countones(enas1()) > 1) begin
      errors++;
      $display("FAIL ena_onehot: got %b / %b required at most one bit", enas0(), enas1());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int o0, input int o1, input logic [W-1:0] v0, input logic [W-1:0] v1);
    c0_inc = (o0 == 1 || o0 == 4); c0_dec = (o0 == 2 || o0 == 4); c0_ld = (o0 == 3); c0_val = v0;
    c1_inc = (o1 == 1 || o1 == 4); c1_dec = (o1 == 2 || o1 == 4); c1_ld = (o1 == 3); c1_val = v1;
  endtask

  task automatic preset(input logic [W-1:0] a, input logic [W-1:0] b);
    pre0 = a; pre1 = b; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    drive(0, 0, '0, '0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, '0, '0);
    {rdy_inc, rdy_dec, rdy_wb} = 3'b111;
    preset('0, '0);
    tick();
    @(negedge clk);
    vectors++;
    if ({enas0(), bus0.c0_ack, bus0.c1_ack, bus0.sat, bus0.proto_err} !== 7'b0) begin
      errors++; $display("FAIL reset_dut0: got %b required 0", {enas0(), bus0.c0_ack, bus0.c1_ack, bus0.sat, bus0.proto_err});
    end
    vectors++;
    if ({enas1(), bus1.c0_ack, bus1.c1_ack, bus1.sat, bus1.proto_err} !== 7'b0) begin
      errors++; $display("FAIL reset_dut1: got %b required 0", {enas1(), bus1.c0_ack, bus1.c1_ack, bus1.sat, bus1.proto_err});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({enas0(), bus0.c0_ack, bus0.c1_ack, bus0.sat, bus0.proto_err} !== 7'b0) begin
      errors++; $display("FAIL post_reset_idle: got %b required 0", {enas0(), bus0.c0_ack, bus0.c1_ack, bus0.sat, bus0.proto_err});
    end
  endtask

  task automatic test_inc();
    preset(10'd5, 10'd5);
    drive(1, 0, '0, '0);
    @(negedge clk);
    vectors++;
    if ({bus0.cnt_increment__ENA, bus0.c0_ack} !== 2'b00) begin
      errors++; $display("FAIL inc_idle: got %b required 00", {bus0.cnt_increment__ENA, bus0.c0_ack});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({bus0.cnt_increment__ENA, bus0.c0_ack, bus1.cnt_increment__ENA, bus1.c0_ack} !== 4'b1111) begin
      errors++; $display("FAIL inc_issue: got %b required 1111", {bus0.cnt_increment__ENA, bus0.c0_ack, bus1.cnt_increment__ENA, bus1.c0_ack});
    end
    tick();
    drive(0, 0, '0, '0);
    vectors++;
    if (cnt0 !== 10'd6) begin errors++; $display("FAIL inc_count: got %0d required 6", cnt0); end
  endtask

  task automatic test_netzero();
    preset(10'd9, 10'd9);
    {rdy_inc, rdy_dec, rdy_wb} = 3'b000;
    drive(1, 2, '0, '0);
    tick();
    @(negedge clk);
    vectors++;
    if ({bus0.c1_ack, bus0.c0_ack, enas0(), bus1.c1_ack, bus1.c0_ack} !== 7'b11_000_11) begin
      errors++; $display("FAIL netzero_ack: got %b required 1100011", {bus0.c1_ack, bus0.c0_ack, enas0(), bus1.c1_ack, bus1.c0_ack});
    end
    tick();
    drive(0, 0, '0, '0);
    {rdy_inc, rdy_dec, rdy_wb} = 3'b111;
    vectors++;
    if (cnt0 !== 10'd9) begin errors++; $display("FAIL netzero_count: got %0d required 9", cnt0); end
  endtask

  task automatic test_load_rr();
    int a0, a1;
    logic [W-1:0] v0, v1;
    logic ld0, ld1;
    do_reset();
    a0 = -1; a1 = -1; v0 = '0; v1 = '0; ld0 = 1; ld1 = 1;
    for (int c = 0; c < 8; c++) begin
      drive(ld0 ? 3 : 0, ld1 ? 3 : 0, 10'h155, 10'h0AA);
      @(negedge clk);
      if (bus0.c0_ack && bus0.cnt_writeBin__ENA) begin a0 = c; v0 = bus0.cnt_writeBin_v; end
      if (bus0.c1_ack && bus0.cnt_writeBin__ENA) begin a1 = c; v1 = bus0.cnt_writeBin_v; end
      tick();
      if (a0 >= 0) ld0 = 0;
      if (a1 >= 0) ld1 = 0;
    end
    drive(0, 0, '0, '0);
    vectors++; if (a0 !== 1) begin errors++; $display("FAIL load_c0_cycle: got %0d required 1", a0); end
    vectors++; if (a1 !== 3) begin errors++; $display("FAIL load_c1_cycle: got %0d required 3", a1); end
    vectors++; if (v0 !== 10'h155) begin errors++; $display("FAIL load_c0_val: got %h required 155", v0); end
    vectors++; if (cnt0 !== 10'h0AA || v1 !== 10'h0AA) begin
      errors++; $display("FAIL load_final: got %h/%h required 0aa", cnt0, v1);
    end
  endtask

  task automatic test_sat();
    preset(10'h3FF, 10'h3FF);
    drive(0, 1, '0, '0);
    tick();
    @(negedge clk);
    vectors++;
    if ({bus1.c1_ack, bus1.sat, bus1.cnt_increment__ENA} !== 3'b110) begin
      errors++; $display("FAIL sat_inc_dut1: got %b required 110", {bus1.c1_ack, bus1.sat, bus1.cnt_increment__ENA});
    end
    vectors++;
    if ({bus0.c1_ack, bus0.sat, bus0.cnt_increment__ENA} !== 3'b101) begin
      errors++; $display("FAIL wrap_inc_dut0: got %b required 101", {bus0.c1_ack, bus0.sat, bus0.cnt_increment__ENA});
    end
    tick();
    drive(0, 0, '0, '0);
    vectors++;
    if ({cnt0, cnt1} !== {10'h000, 10'h3FF}) begin errors++; $display("FAIL sat_inc_count: got %h/%h required 000/3ff", cnt0, cnt1); end

    preset('0, '0);
    drive(2, 0, '0, '0);
    tick();
    @(negedge clk);
    vectors++;
    if ({bus1.c0_ack, bus1.sat, bus1.cnt_decrement__ENA, bus0.c0_ack, bus0.sat, bus0.cnt_decrement__ENA} !== 6'b110_101) begin
      errors++; $display("FAIL sat_dec: got %b required 110101",
        {bus1.c0_ack, bus1.sat, bus1.cnt_decrement__ENA, bus0.c0_ack, bus0.sat, bus0.cnt_decrement__ENA});
    end
    tick();
    drive(0, 0, '0, '0);
    vectors++;
    if ({cnt0, cnt1} !== {10'h3FF, 10'h000}) begin errors++; $display("FAIL sat_dec_count: got %h/%h required 3ff/000", cnt0, cnt1); end

    preset(10'h3FF, 10'h3FF);
    drive(3, 0, 10'h012, '0);
    tick();
    @(negedge clk);
    vectors++;
    if ({bus1.c0_ack, bus1.sat, bus1.cnt_writeBin__ENA} !== 3'b101) begin
      errors++; $display("FAIL sat_load_dut1: got %b required 101", {bus1.c0_ack, bus1.sat, bus1.cnt_writeBin__ENA});
    end
    tick();
    drive(0, 0, '0, '0);
  endtask

  task automatic test_rdy_stall();
    preset(10'd7, 10'd7);
    rdy_dec = 1'b0;
    drive(2, 0, '0, '0);
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      tick();
      rdy_dec = (c == 4);
      @(negedge clk);
      vectors++;
      if ({bus0.cnt_decrement__ENA, bus0.c0_ack} !== ((c == 4) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL stall_c%0d: got %b required %b", c, {bus0.cnt_decrement__ENA, bus0.c0_ack}, (c == 4) ? 2'b11 : 2'b00);
      end
    end
    tick();
    drive(0, 0, '0, '0);
    vectors++;
    if (cnt0 !== 10'd6) begin errors++; $display("FAIL stall_count: got %0d required 6", cnt0); end

    rdy_dec = 1'b0;
    drive(2, 0, '0, '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus0.cnt_decrement__ENA, bus0.c0_ack} !== 2'b00) begin
      errors++; $display("FAIL stall_rst: got %b required 00", {bus0.cnt_decrement__ENA, bus0.c0_ack});
    end
    tick();
    rst = 1'b0;
    rdy_dec = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus0.cnt_decrement__ENA, bus0.c0_ack} !== 2'b00) begin
      errors++; $display("FAIL post_rst_idle: got %b required 00", {bus0.cnt_decrement__ENA, bus0.c0_ack});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({bus0.cnt_decrement__ENA, bus0.c0_ack} !== 2'b11) begin
      errors++; $display("FAIL post_rst_retry: got %b required 11", {bus0.cnt_decrement__ENA, bus0.c0_ack});
    end
    tick();
    drive(0, 0, '0, '0);
    vectors++;
    if (cnt0 !== 10'd5) begin errors++; $display("FAIL retry_count: got %0d required 5", cnt0); end
  endtask

  task automatic test_proto();
    do_reset();
    drive(4, 0, '0, '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (bus0.c0_ack !== 1'b0 || enas0() !== 3'b000) begin
        errors++; $display("FAIL proto_noack_c%0d: got %b/%b required 0/000", c, bus0.c0_ack, enas0());
      end
      if (c >= 1) begin
        vectors++;
        if (bus0.proto_err !== 1'b1) begin errors++; $display("FAIL proto_set_c%0d: got %b required 1", c, bus0.proto_err); end
      end
      tick();
    end
    drive(0, 0, '0, '0);
    tick(); tick();
    @(negedge clk);
    vectors++;
    if (bus0.proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b required 1", bus0.proto_err); end
    do_reset();
    @(negedge clk);
    vectors++;
    if (bus0.proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b required 0", bus0.proto_err); end
  endtask

  task automatic test_random();
    int rr, mode, s, w, last, idx;
    int o[2], ta[2];
    logic [W-1:0] v[2];
    logic [W-1:0] exp, bnd;
    bit pend[2];
    logic [1:0] acks;
    logic [2:0] eena;
    do_reset();
    rr = 0;
    exp = '0;
    for (int it = 0; it < 40; it++) begin
      if (it % 5 == 0) begin
        bnd = ($urandom_range(0, 1) == 1) ? {W{1'b1}} : W'($urandom_range(0, 1023));
        preset(bnd, bnd);
        exp = bnd;
      end
      mode = $urandom_range(0, 3);
      s    = $urandom_range(0, 2);
      v[0] = W'($urandom); v[1] = W'($urandom);
      o[0] = 0; o[1] = 0; ta[0] = -1; ta[1] = -1;
      case (mode)
        0: begin
          w = $urandom_range(0, 1);
          o[w] = $urandom_range(1, 3);
          ta[w] = 1 + s;
          exp = apply(exp, o[w], v[w]);
          rr = 1 - w;
        end
        1, 3: begin
          o[0] = (mode == 3) ? 3 : $urandom_range(1, 2);
          o[1] = o[0];
          w = rr;
          ta[w] = 1 + s;
          ta[1 - w] = 3 + s;
          exp = apply(apply(exp, o[w], v[w]), o[1 - w], v[1 - w]);
        end
        default: begin
          o[0] = $urandom_range(1, 2);
          o[1] = 3 - o[0];
          ta[0] = 1; ta[1] = 1;
        end
      endcase
      last = (ta[0] > ta[1]) ? ta[0] : ta[1];
      pend[0] = (o[0] != 0); pend[1] = (o[1] != 0);
      for (int c = 0; c <= last; c++) begin
        drive(pend[0] ? o[0] : 0, pend[1] ? o[1] : 0, v[0], v[1]);
        {rdy_inc, rdy_dec, rdy_wb} = (c >= s + 1) ? 3'b111 : 3'b000;
        eena = 3'b000;
        for (int k = 0; k < 2; k++)
          if (ta[k] == c && mode != 2) eena = eena | ena_of(o[k]);
        idx = (ta[1] == c) ? 1 : 0;
        @(negedge clk);
        acks = {bus0.c1_ack, bus0.c0_ack};
        vectors++;
        if (acks !== {ta[1] == c, ta[0] == c}) begin
          errors++; $display("FAIL rand_ack it%0d c%0d: got %b required %b", it, c, acks, {ta[1] == c, ta[0] == c});
        end
        vectors++;
        if (enas0() !== eena || bus0.sat !== 1'b0) begin
          errors++; $display("FAIL rand_ena it%0d c%0d: got %b sat %b required %b sat 0", it, c, enas0(), bus0.sat, eena);
        end
        if (eena[2]) begin
          vectors++;
          if (bus0.cnt_writeBin_v !== v[idx]) begin
            errors++; $display("FAIL rand_wbv it%0d: got %h required %h", it, bus0.cnt_writeBin_v, v[idx]);
          end
        end
        tick();
        if (acks[0]) pend[0] = 0;
        if (acks[1]) pend[1] = 0;
        drive(pend[0] ? o[0] : 0, pend[1] ? o[1] : 0, v[0], v[1]);
      end
      vectors++;
      if (cnt0 !== exp) begin errors++; $display("FAIL rand_count it%0d: got %h required %h", it, cnt0, exp); end
    end
    {rdy_inc, rdy_dec, rdy_wb} = 3'b111;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_inc();
    test_netzero();
    test_load_rr();
    test_sat();
    test_rdy_stall();
    test_proto();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
